upe_add32_uu: RTL and testbench
===============================

Name:
upe_add32_uu

Overview:
- Registered 32-bit unsigned + unsigned adder with carry-in and carry-out, built from carry-lookahead groups.
- Arithmetic primitive of the uncertainty-propagation datapath; on the iCE40 board it runs off the 10 kHz SB_LFOSC clock (`clk`).
- One result per accepted operand pair, one-cycle latency; result held until the next accepted pair.

Parameters:
- WIDTH, 32, operand/result width; legal values are multiples of 4. Default build and all tests use 32.
- GROUP, 4, carry-lookahead group size in bits; WIDTH must be a multiple of GROUP.

Ports:
- clk  input  1  system clock, rising-edge active (SB_LFOSC CLKLF on board)
- rst  input  1  reset, synchronous, active-high
- AB  input  WIDTH  first unsigned operand
- CD  input  WIDTH  second unsigned operand
- carryin  input  1  carry into bit 0
- in_valid  input  1  operands/carryin valid this cycle; sampled on rising clk
- Out  output  WIDTH  registered sum bits [WIDTH-1:0]
- carryout  output  1  registered carry out of bit WIDTH-1 (unsigned overflow)
- out_valid  output  1  registered; high for exactly one cycle per accepted pair

Behaviour:
- Reset: on a rising clk with rst=1, Out=0, carryout=0 and out_valid=0. rst has priority over in_valid. Asserting rst mid-stream discards the pair sampled on that edge.
- Arithmetic:
  - {carryout, Out} = AB + CD + carryin, computed WIDTH+1 bits wide with no truncation before the top carry.
  - Operands are unsigned. No saturation and no signed overflow flag.
- Structure:
  - Per-bit generate g = a&b and propagate p = a^b.
  - Per GROUP: group generate/propagate and internal carries by lookahead equations.
  - Group carries ripple group to group.
  - Sum bit = p ^ carry-in-to-bit.
  - The whole sum path is combinational between the input ports and the output registers.
- Latency: operands sampled on edge N with in_valid=1 produce Out/carryout valid after edge N, with out_valid=1 during cycle N+1.
- Throughput: one pair per cycle. Back-to-back in_valid produces back-to-back out_valid.
- in_valid=0 on an edge (rst=0): Out and carryout hold their previous values and out_valid=0.
- No backpressure: the consumer must take the result while out_valid=1. Held data remains readable afterwards.
- Wrap-around: the all-ones + 0 + carryin=1 case wraps Out to 0 with carryout=1.
- X/undefined operands while in_valid=0 must not change the outputs.

Test Plan:
- Basic sum: rst for 2 cycles, then AB=0x67510B12, CD=0xCD840A1F, carryin=0, in_valid=1 for one cycle -> next cycle Out=0x34D51531, carryout=1, out_valid=1. On the following cycle out_valid=0 and Out holds 0x34D51531.
- Carry chain full length: AB=0xFFFFFFFF, CD=0x00000000, carryin=1 -> Out=0x00000000, carryout=1. Then AB=0xFFFFFFFF, CD=0, carryin=0 -> Out=0xFFFFFFFF, carryout=0.
- Back-to-back pairs, one per cycle, with carryin=0, each result appearing one cycle after its operands:
  - AB=0x7F7DF7D8, CD=0xFFFFFFFF -> Out=0x7F7DF7D7, carryout=1.
  - AB=0x55555556, CD=0xFFFFFFFF -> Out=0x55555555, carryout=1.
  - out_valid stays high for both cycles.
- Group boundaries: AB=0x0000000F, CD=0x00000001, carryin=0 -> Out=0x00000010, carryout=0. AB=0x0FFFFFFF, CD=0x00000001 -> Out=0x10000000, carryout=0.
- Reset mid-operation: load any pair with in_valid=1 and rst=1 on the same edge -> Out=0, carryout=0, out_valid=0 next cycle.
- Random/exhaustive sweep: compare registered outputs against a 33-bit reference sum for ≥10k random AB/CD/carryin, including in_valid gaps. Verify outputs hold across every gap.

Source files
------------

// File: rtl/upe_add32_uu.sv
// ---------------------------------------------------------------------------
// upe_add32_uu
// Registered unsigned + unsigned adder with carry-in and carry-out, built
// from carry-lookahead groups whose group carries ripple from group to group.
// One result per accepted operand pair, one-cycle latency. The result is
// held until the next accepted pair.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over in_valid)
//   AB, CD     unsigned operands, WIDTH bits
//   carryin    carry into bit 0
//   in_valid   operands/carryin valid this cycle
//   Out        registered sum bits [WIDTH-1:0]
//   carryout   registered carry out of bit WIDTH-1
//   out_valid  registered, high for one cycle per accepted pair
// ---------------------------------------------------------------------------
module upe_add32_uu #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] AB,
  input  logic [WIDTH-1:0] CD,
  input  logic             carryin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Out,
  output logic             carryout,
  output logic             out_valid
);

  localparam int NGRP = WIDTH / GROUP;

  logic [WIDTH-1:0] gen_s;
  logic [WIDTH-1:0] prop_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;

  logic [WIDTH-1:0] out_r;
  logic             cout_r;
  logic             vld_r;

  // Per-bit generate and propagate terms.
  assign gen_s  = AB & CD;
  assign prop_s = AB ^ CD;

  // Lookahead inside each group, group carry rippling to the next group.
  always_comb begin
    logic grp_c;
    logic bit_c;
    logic run_p;
    logic grp_g;
    logic grp_p;
    sum_s  = {WIDTH{1'b0}};
    cout_s = 1'b0;
    grp_c  = carryin;
    bit_c  = 1'b0;
    run_p  = 1'b1;
    grp_g  = 1'b0;
    grp_p  = 1'b1;
    for (int k = 0; k < NGRP; k++) begin
      // Carry into bit i of the group as a flat sum of products:
      // g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]&cin_group.
      for (int i = 0; i < GROUP; i++) begin
        bit_c = 1'b0;
        run_p = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          bit_c = bit_c | (run_p & gen_s[k*GROUP + j]);
          run_p = run_p & prop_s[k*GROUP + j];
        end
        bit_c = bit_c | (run_p & grp_c);
        sum_s[k*GROUP + i] = prop_s[k*GROUP + i] ^ bit_c;
      end
      // Group generate/propagate, independent of the incoming group carry.
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = GROUP - 1; j >= 0; j--) begin
        grp_g = grp_g | (grp_p & gen_s[k*GROUP + j]);
        grp_p = grp_p & prop_s[k*GROUP + j];
      end
      grp_c = grp_g | (grp_p & grp_c);
    end
    cout_s = grp_c;
  end

  // Output registers: load on an accepted pair, otherwise hold data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      vld_r  <= 1'b0;
    end else if (in_valid) begin
      out_r  <= sum_s;
      cout_r <= cout_s;
      vld_r  <= 1'b1;
    end else begin
      vld_r  <= 1'b0;
    end
  end

  assign Out       = out_r;
  assign carryout  = cout_r;
  assign out_valid = vld_r;

endmodule

// File: tb/tb_upe_add32_uu.sv
module tb_upe_add32_uu;

  logic        clk;
  logic        rst;
  logic [31:0] AB;
  logic [31:0] CD;
  logic        carryin;
  logic        in_valid;
  logic [31:0] Out;
  logic        carryout;
  logic        out_valid;

  int n_tests;
  int n_fail;

  // Reference state: last accepted result, as the spec defines it.
  logic [31:0] ref_out;
  logic        ref_co;

  upe_add32_uu #(.WIDTH(32), .GROUP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .AB       (AB),
    .CD       (CD),
    .carryin  (carryin),
    .in_valid (in_valid),
    .Out      (Out),
    .carryout (carryout),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after an edge, then advance through the next edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic v, input logic r);
    AB = a; CD = b; carryin = ci; in_valid = v; rst = r;
    @(posedge clk);
    #1;
  endtask

  // 33-bit reference: plain integer arithmetic.
  function automatic logic [32:0] ref_sum(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic ci);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    return s;
  endfunction

  task automatic test_reset();
    step(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 1'b1);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (Out !== 32'h0 || carryout !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: Out=%h co=%b vld=%b, expected 0/0/0", Out, carryout, out_valid);
    end
    ref_out = 32'h0; ref_co = 1'b0;
  endtask

  task automatic test_basic();
    step(32'h6751_0B12, 32'hCD84_0A1F, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (Out !== 32'h34D5_1531 || carryout !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic: Out=%h co=%b vld=%b, expected 34d51531/1/1", Out, carryout, out_valid);
    end
    step(32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'bx, 1'b0, 1'b0);
    n_tests++;
    if (Out !== 32'h34D5_1531 || carryout !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: Out=%h co=%b vld=%b, expected 34d51531/1/0", Out, carryout, out_valid);
    end
  endtask

  task automatic test_carry_chain();
    step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (Out !== 32'h0000_0000 || carryout !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: Out=%h co=%b vld=%b, expected 00000000/1/1", Out, carryout, out_valid);
    end
    step(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (Out !== 32'hFFFF_FFFF || carryout !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL all_ones: Out=%h co=%b vld=%b, expected ffffffff/0/1", Out, carryout, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    step(32'h7F7D_F7D8, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (Out !== 32'h7F7D_F7D7 || carryout !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: Out=%h co=%b vld=%b, expected 7f7df7d7/1/1", Out, carryout, out_valid);
    end
    step(32'h5555_5556, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (Out !== 32'h5555_5555 || carryout !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: Out=%h co=%b vld=%b, expected 55555555/1/1", Out, carryout, out_valid);
    end
  endtask

  task automatic test_group_boundary();
    step(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (Out !== 32'h0000_0010 || carryout !== 1'b0) begin
      n_fail++;
      $display("FAIL group_low: Out=%h co=%b, expected 00000010/0", Out, carryout);
    end
    step(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (Out !== 32'h1000_0000 || carryout !== 1'b0) begin
      n_fail++;
      $display("FAIL group_high: Out=%h co=%b, expected 10000000/0", Out, carryout);
    end
    step(32'h0000_FFF0, 32'h0000_000F, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (Out !== 32'h0001_0000 || carryout !== 1'b0) begin
      n_fail++;
      $display("FAIL group_cin: Out=%h co=%b, expected 00010000/0", Out, carryout);
    end
  endtask

  task automatic test_reset_mid();
    step(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1, 1'b0);
    step(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (Out !== 32'h0 || carryout !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: Out=%h co=%b vld=%b, expected 0/0/0", Out, carryout, out_valid);
    end
    ref_out = 32'h0; ref_co = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        ci, v;
    logic [32:0] s;
    for (int it = 0; it < 12000; it++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      if (v) begin
        step(a, b, ci, 1'b1, 1'b0);
        s = ref_sum(a, b, ci);
        ref_out = s[31:0];
        ref_co  = s[32];
      end else begin
        step(32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'bx, 1'b0, 1'b0);
      end
      n_tests++;
      if (Out !== ref_out || carryout !== ref_co || out_valid !== v) begin
        n_fail++;
        $display("FAIL random[%0d]: Out=%h co=%b vld=%b, expected %h/%b/%b",
                 it, Out, carryout, out_valid, ref_out, ref_co, v);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ref_out = 32'h0;
    ref_co  = 1'b0;
    rst = 1'b1; in_valid = 1'b0; AB = 32'h0; CD = 32'h0; carryin = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_group_boundary();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
